id_stage: RTL



---
 rtl/mips_pkg.sv | 43 ++++
 rtl/id_stage_if.sv | 32 +++
 rtl/id_scoreboard.sv | 56 +++++
 rtl/id_stage.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, decode result type and the decode helper for id_stage.
package mips_pkg;

    localparam int REGFILE_SIZE = 32;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_JR      = 6'h08;

    typedef struct packed {
        logic [4:0]  wadr;
        logic        wren;
        logic [31:0] ed32;
    } decode_t;

    // wren is the opcode-level rule only; the caller masks writes to register 0
    // after truncating wadr to its own address width.
    function automatic decode_t decode(input logic [31:0] ins);
        decode_t    d;
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == OP_SPECIAL)
            d.wadr = ins[15:11];
        else if (op == OP_JAL)
            d.wadr = 5'h1F;
        else
            d.wadr = ins[20:16];
        d.wren = ((op == OP_SPECIAL) && (fn != FN_JR)) || (op == OP_JAL) ||
                 ((op > OP_BGTZ) && (op != OP_SW));
        if ((op >= OP_ADDI) && (op <= OP_XORI))
            d.ed32 = {16'h0000, ins[15:0]};
        else
            d.ed32 = {{16{ins[15]}}, ins[15:0]};
        return d;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Handshake, write-back and decoded-output bundle between fetch, id_stage and execute.
interface id_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       Ins;
    logic              flush;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_adr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] Rdata1;
    logic [DATA_W-1:0] Rdata2;
    logic [DATA_W-1:0] Ed32;
    logic [ADDR_W-1:0] Wadr;
    logic              WrEn;
    logic [5:0]        Opcode;
    logic [5:0]        Funct;

    modport master (
        output in_valid, Ins, flush, wb_en, wb_adr, wb_data, out_ready,
        input  in_ready, out_valid, Rdata1, Rdata2, Ed32, Wadr, WrEn, Opcode, Funct
    );

    modport slave (
        input  in_valid, Ins, flush, wb_en, wb_adr, wb_data, out_ready,
        output in_ready, out_valid, Rdata1, Rdata2, Ed32, Wadr, WrEn, Opcode, Funct
    );
endinterface

// File: rtl/id_scoreboard.sv
// Per-register busy bits for id_stage. With ID_BYPASS_EN a same-cycle write-back
// hides its busy bit from the hazard query; otherwise the bit stays visible until the edge.
module id_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = $clog2(REG_NUM)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_adr,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_adr,
    input  logic              flush_clr,
    input  logic [ADDR_W-1:0] flush_adr,
    input  logic [ADDR_W-1:0] q_adr1,
    input  logic [ADDR_W-1:0] q_adr2,
    input  logic [ADDR_W-1:0] q_adr3,
    output logic              hazard
);

    logic [REG_NUM-1:0] busy_reg;
    logic [REG_NUM-1:0] busy_next;
    logic [REG_NUM-1:0] set_mask;
    logic [REG_NUM-1:0] clr_mask;
    logic [REG_NUM-1:0] visible;

    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_bit
            assign set_mask[gi] = set && (set_adr == ADDR_W'(gi));
            assign clr_mask[gi] = (clr && (clr_adr == ADDR_W'(gi))) ||
                                  (flush_clr && (flush_adr == ADDR_W'(gi)));
            // Set wins over a same-cycle clear; register 0 can never become busy.
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_nz
                assign busy_next[gi] = set_mask[gi] || (busy_reg[gi] && !clr_mask[gi]);
            end
`ifdef ID_BYPASS_EN
            assign visible[gi] = busy_reg[gi] && !(clr && (clr_adr == ADDR_W'(gi)));
`else
            assign visible[gi] = busy_reg[gi];
`endif
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            busy_reg <= '0;
        else
            busy_reg <= busy_next;
    end

    assign hazard = visible[q_adr1] || visible[q_adr2] || visible[q_adr3];

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: register file, decode, busy scoreboard and
// valid/ready output register. Optional same-cycle write-back forwarding via ID_BYPASS_EN.
module id_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = REGFILE_SIZE
) (
    input logic     CLK,
    input logic     RST,
    id_stage_if.slave bus
);

    localparam int ADDR_W = $clog2(REG_NUM);

    logic [DATA_W-1:0] regs [REG_NUM];

    decode_t           dec;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] wadr;
    logic              wren;
    logic [DATA_W-1:0] ed;
    logic [DATA_W-1:0] src_data [2];
    logic [ADDR_W-1:0] src_adr  [2];
    logic              hazard;
    logic              issue;

    logic              out_valid_reg;
    logic [DATA_W-1:0] rdata1_reg;
    logic [DATA_W-1:0] rdata2_reg;
    logic [DATA_W-1:0] ed_reg;
    logic [ADDR_W-1:0] wadr_reg;
    logic              wren_reg;
    logic [5:0]        opcode_reg;
    logic [5:0]        funct_reg;

    assign dec  = decode(bus.Ins);
    assign rs   = bus.Ins[21 +: ADDR_W];
    assign rt   = bus.Ins[16 +: ADDR_W];
    assign wadr = dec.wadr[ADDR_W-1:0];
    assign wren = dec.wren && (wadr != '0);

    // The zero-extended case has bit 31 clear, so replicating it is correct for both kinds.
    generate
        if (DATA_W <= 32) begin : g_ed_narrow
            assign ed = dec.ed32[DATA_W-1:0];
        end else begin : g_ed_wide
            assign ed = {{(DATA_W-32){dec.ed32[31]}}, dec.ed32};
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < REG_NUM; i++)
                regs[i] <= '0;
        end else if (bus.wb_en && (bus.wb_adr != '0)) begin
            regs[bus.wb_adr] <= bus.wb_data;
        end
    end

    assign src_adr[0] = rs;
    assign src_adr[1] = rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                src_data[gi] = regs[src_adr[gi]];
`ifdef ID_BYPASS_EN
                if (bus.wb_en && (bus.wb_adr == src_adr[gi]) && (src_adr[gi] != '0))
                    src_data[gi] = bus.wb_data;
`endif
            end
        end
    endgenerate

    id_scoreboard #(
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W)
    ) u_scoreboard (
        .CLK       (CLK),
        .RST       (RST),
        .set       (issue && wren),
        .set_adr   (wadr),
        .clr       (bus.wb_en),
        .clr_adr   (bus.wb_adr),
        .flush_clr (bus.flush && out_valid_reg && wren_reg),
        .flush_adr (wadr_reg),
        .q_adr1    (rs),
        .q_adr2    (rt),
        .q_adr3    (wren ? wadr : '0),
        .hazard    (hazard)
    );

    assign bus.in_ready = !RST && (!out_valid_reg || bus.out_ready) && !hazard && !bus.flush;
    assign issue        = bus.in_valid && bus.in_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_reg <= 1'b0;
            rdata1_reg    <= '0;
            rdata2_reg    <= '0;
            ed_reg        <= '0;
            wadr_reg      <= '0;
            wren_reg      <= 1'b0;
            opcode_reg    <= '0;
            funct_reg     <= '0;
        end else if (issue) begin
            out_valid_reg <= 1'b1;
            rdata1_reg    <= src_data[0];
            rdata2_reg    <= src_data[1];
            ed_reg        <= ed;
            wadr_reg      <= wadr;
            wren_reg      <= wren;
            opcode_reg    <= bus.Ins[31:26];
            funct_reg     <= bus.Ins[5:0];
        end else if (bus.flush || bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.Rdata1    = rdata1_reg;
    assign bus.Rdata2    = rdata2_reg;
    assign bus.Ed32      = ed_reg;
    assign bus.Wadr      = wadr_reg;
    assign bus.WrEn      = wren_reg;
    assign bus.Opcode    = opcode_reg;
    assign bus.Funct     = funct_reg;

endmodule
